// File: rtl/miner_pkg.sv
// miner_pkg: shared types and constants for the nonce reporting path.
//   rpt_state_t - report FSM states of the transmitter arbiter
//   NONCE_W     - default nonce / transmitter word width
//   DROP_CNT_W  - width of the saturating dropped-nonce counter
package miner_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} rpt_state_t;
    localparam int NONCE_W    = 32;
    localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
//   req     - per-requester request bits
//   ptr     - index holding highest priority this cycle
//   gnt     - one-hot grant (zero when nothing requested)
//   gnt_idx - index of the granted requester
//   any     - at least one request present
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    int c;
    always_comb begin
        c       = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            c = (c >= N) ? c - N : c;
            if (!any && req[c]) begin
                any     = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end
    assign gnt = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/nonce_report_arbiter.sv
// nonce_report_arbiter: buffers one found nonce per hashing core and reports them,
// round-robin, one word at a time through the shared UART result transmitter.
//   clk, reset_n - clock and asynchronous active-low reset
//   core_valid   - per-core 1-cycle "nonce found" pulse
//   core_nonce   - core i nonce at [i*NONCE_W +: NONCE_W]
//   job_flush    - 1-cycle pulse: discard all buffered nonces
//   tx_busy      - transmitter busy
//   tx_send      - 1-cycle send request; tx_word holds its word until the next grant
//   pending      - per-core slot occupied
//   drop_cnt     - saturating count of cycles in which a nonce hit a full slot
//   tx_err       - sticky: a send never saw tx_busy rise within BUSY_TMO cycles
module nonce_report_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = miner_pkg::NONCE_W,
    parameter int BUSY_TMO  = 15
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CORES-1:0]               core_valid,
    input  logic [NUM_CORES*NONCE_W-1:0]       core_nonce,
    input  logic                               job_flush,
    input  logic                               tx_busy,
    output logic                               tx_send,
    output logic [NONCE_W-1:0]                 tx_word,
    output logic [NUM_CORES-1:0]               pending,
    output logic [miner_pkg::DROP_CNT_W-1:0]   drop_cnt,
    output logic                               tx_err
);
    import miner_pkg::*;

    localparam int IW = $clog2(NUM_CORES);
    localparam int TW = $clog2(BUSY_TMO + 1);

    rpt_state_t            state_q, state_d;
    logic [NUM_CORES-1:0]  slot_v_q, slot_v_d, gnt, gnt_en, cap;
    logic [NONCE_W-1:0]    slot_q [NUM_CORES];
    logic [IW-1:0]         ptr_q, ptr_d, gnt_idx;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  send_q, send_d, err_q, err_d;
    logic [NONCE_W-1:0]    word_q, word_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  any, grant, drop;

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .req     (slot_v_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // A slot being granted this cycle frees up in time to take a new nonce.
    assign gnt_en   = {NUM_CORES{grant}} & gnt;
    assign cap      = core_valid & (~slot_v_q | gnt_en);
    assign drop     = !job_flush && |(core_valid & slot_v_q & ~gnt_en);
    assign slot_v_d = job_flush ? '0 : (slot_v_q & ~gnt_en) | cap;
    assign drop_d   = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        send_d  = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE: if (any && !tx_busy) begin
                grant   = 1'b1;
                send_d  = 1'b1;
                word_d  = slot_q[gnt_idx];
                ptr_d   = (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_HI;
                timer_d = '0;
            end
            // The timer counts WAIT_HI cycles; the last allowed one gives up.
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
                     else if (timer_q == TW'(BUSY_TMO - 1)) begin
                         err_d   = 1'b1;
                         state_d = IDLE;
                     end else timer_d = timer_q + 1'b1;
            WAIT_LO: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            slot_v_q <= '0;
            ptr_q    <= '0;
            timer_q  <= '0;
            send_q   <= 1'b0;
            word_q   <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_v_q <= slot_v_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            send_q   <= send_d;
            word_q   <= word_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++)
                if (cap[i]) slot_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
        end
    end

    assign tx_send  = send_q;
    assign tx_word  = word_q;
    assign pending  = slot_v_q;
    assign drop_cnt = drop_q;
    assign tx_err   = err_q;
endmodule

// File: tb/tb_nonce_report_arbiter.sv
// tb_nonce_report_arbiter: vector table, directed corner sequences and a random run
// against a report-lifecycle reference model for nonce_report_arbiter.
module tb_nonce_report_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   core_valid = '0;
    logic [N*W-1:0] core_nonce = '0;
    logic           job_flush = 1'b0;
    logic           tx_busy = 1'b0;
    logic           tx_send;
    logic [W-1:0]   tx_word;
    logic [N-1:0]   pending;
    logic [7:0]     drop_cnt;
    logic           tx_err;

    always #5 clk = ~clk;

    nonce_report_arbiter #(.NUM_CORES(N), .NONCE_W(W), .BUSY_TMO(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_valid (core_valid),
        .core_nonce (core_nonce),
        .job_flush  (job_flush),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_word    (tx_word),
        .pending    (pending),
        .drop_cnt   (drop_cnt),
        .tx_err     (tx_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input bit s, input logic [31:0] w,
                           input logic [3:0] p, input logic [7:0] d, input bit e);
        chk({nm, ".tx_send"},  32'(tx_send),  32'(s));
        chk({nm, ".tx_word"},  tx_word,       w);
        chk({nm, ".pending"},  32'(pending),  32'(p));
        chk({nm, ".drop_cnt"}, 32'(drop_cnt), 32'(d));
        chk({nm, ".tx_err"},   32'(tx_err),   32'(e));
    endtask

    task automatic drv(input logic [3:0] v, input logic [127:0] nv, input bit fl, input bit bz);
        core_valid = v;
        core_nonce = nv;
        job_flush  = fl;
        tx_busy    = bz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] nv4(input logic [31:0] a3, input logic [31:0] a2,
                                         input logic [31:0] a1, input logic [31:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // ---------------- reference model: pending slots + one report lifecycle
    bit          m_pend [N];
    logic [31:0] m_val  [N];
    int          m_ptr, m_age, m_drops;
    bit          m_active, m_acked, m_send, m_err;
    logic [31:0] m_word;

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 1'b0;
            m_val[c]  = '0;
        end
        m_ptr = 0; m_age = 0; m_drops = 0;
        m_active = 0; m_acked = 0; m_send = 0; m_err = 0;
        m_word = '0;
    endtask

    function automatic logic [3:0] m_pvec();
        logic [3:0] r;
        for (int c = 0; c < N; c++) r[c] = m_pend[c];
        return r;
    endfunction

    // Advance the model across one clock edge given that cycle's inputs.
    task automatic m_step(input logic [3:0] v, input logic [127:0] nv, input bit fl, input bit bz);
        int g;
        bit lost;
        g = -1;
        lost = 0;
        if (!m_active && !bz)
            for (int k = 0; k < N; k++)
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (m_send) begin
            m_send = 0; m_age = 0; m_acked = 0;
        end else if (m_active && !m_acked) begin
            if (bz) m_acked = 1;
            else begin
                m_age++;
                if (m_age == TMO) begin m_active = 0; m_err = 1; end
            end
        end else if (m_active && !bz) m_active = 0;
        if (g >= 0) begin
            m_word = m_val[g]; m_pend[g] = 0; m_send = 1; m_active = 1;
            m_ptr = (g + 1) % N;
        end
        for (int c = 0; c < N; c++)
            if (v[c]) begin
                if (m_pend[c]) lost = 1;
                else begin m_pend[c] = 1; m_val[c] = nv[c*W +: W]; end
            end
        if (fl) begin
            for (int c = 0; c < N; c++) m_pend[c] = 0;
            lost = 0;
        end
        if (lost && m_drops < 255) m_drops++;
    endtask

    // ---------------- vector table
    typedef struct {
        bit           rst;
        logic [3:0]   v;
        logic [127:0] nv;
        bit           fl;
        bit           bz;
        int           rep;
        bit           s;
        logic [31:0]  w;
        logic [3:0]   p;
        logic [7:0]   d;
        bit           e;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rst, input logic [3:0] v, input logic [127:0] nv, input bit fl,
                       input bit bz, input int rep, input bit s, input logic [31:0] w,
                       input logic [3:0] p, input logic [7:0] d, input bit e);
        vec_t t;
        t.rst = rst; t.v = v; t.nv = nv; t.fl = fl; t.bz = bz; t.rep = rep;
        t.s = s; t.w = w; t.p = p; t.d = d; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drv('0, '0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;
        m_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]   rv;
        logic [127:0] rn;
        bit           rf, rb;
        int           e_wait, e_len;

        // single report from core 2
        add(1, 4'b0000, '0, 0, 0, 2,  0, 32'h0, 4'b0000, 0, 0);
        add(0, 4'b0100, nv4(0, 32'hDEADBEEF, 0, 0), 0, 0, 1, 0, 32'h0, 4'b0100, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'hDEADBEEF, 4'b0000, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'hDEADBEEF, 4'b0000, 0, 0);
        add(0, 4'b0000, '0, 0, 1, 20, 0, 32'hDEADBEEF, 4'b0000, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 2,  0, 32'hDEADBEEF, 4'b0000, 0, 0);
        // round robin: 0,1,3 together, then 0 re-requests while 3 waits
        add(1, 4'b0000, '0, 0, 0, 1,  0, 32'h0, 4'b0000, 0, 0);
        add(0, 4'b1011, nv4(4, 0, 2, 1), 0, 0, 1, 0, 32'h0, 4'b1011, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'h1, 4'b1010, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h1, 4'b1010, 0, 0);
        add(0, 4'b0000, '0, 0, 1, 1,  0, 32'h1, 4'b1010, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h1, 4'b1010, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'h2, 4'b1000, 0, 0);
        add(0, 4'b0001, nv4(0, 0, 0, 8), 0, 0, 1, 0, 32'h2, 4'b1001, 0, 0);
        add(0, 4'b0000, '0, 0, 1, 1,  0, 32'h2, 4'b1001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h2, 4'b1001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'h4, 4'b0001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h4, 4'b0001, 0, 0);
        add(0, 4'b0000, '0, 0, 1, 1,  0, 32'h4, 4'b0001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h4, 4'b0001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'h8, 4'b0000, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h8, 4'b0000, 0, 0);
        // overflow while a report is in flight, then flush with busy transmitter
        add(1, 4'b0000, '0, 0, 0, 1,  0, 32'h0, 4'b0000, 0, 0);
        add(0, 4'b0001, nv4(0, 0, 0, 32'hA), 0, 0, 1, 0, 32'h0, 4'b0001, 0, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'hA, 4'b0000, 0, 0);
        add(0, 4'b0010, nv4(0, 0, 5, 0), 0, 0, 1, 0, 32'hA, 4'b0010, 0, 0);
        add(0, 4'b0010, nv4(0, 0, 6, 0), 0, 1, 1, 0, 32'hA, 4'b0010, 1, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'hA, 4'b0010, 1, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  1, 32'h5, 4'b0000, 1, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h5, 4'b0000, 1, 0);
        add(0, 4'b0000, '0, 0, 1, 1,  0, 32'h5, 4'b0000, 1, 0);
        add(0, 4'b0000, '0, 0, 0, 1,  0, 32'h5, 4'b0000, 1, 0);
        add(0, 4'b0101, nv4(0, 32'h33, 0, 32'h11), 0, 1, 1, 0, 32'h5, 4'b0101, 1, 0);
        add(0, 4'b0000, '0, 0, 1, 3,  0, 32'h5, 4'b0101, 1, 0);
        add(0, 4'b1001, nv4(32'h44, 0, 0, 32'h55), 1, 1, 1, 0, 32'h5, 4'b0000, 1, 0);
        add(0, 4'b0000, '0, 0, 0, 3,  0, 32'h5, 4'b0000, 1, 0);

        foreach (tbl[i]) begin
            reset_n = !tbl[i].rst;
            drv(tbl[i].v, tbl[i].nv, tbl[i].fl, tbl[i].bz);
            for (int r = 0; r < tbl[i].rep; r++) begin
                tick();
                chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].w, tbl[i].p, tbl[i].d, tbl[i].e);
            end
        end

        // drop counter saturation; two drops in one cycle count once
        do_reset();
        drv(4'b0011, nv4(0, 0, 32'h22, 32'h21), 0, 1); tick();
        chk("sat.pend", 32'(pending), 32'h3);
        drv(4'b0011, nv4(0, 0, 32'h32, 32'h31), 0, 1); tick();
        chk("sat.double", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 253; i++) begin drv(4'b0001, nv4(0, 0, 0, i), 0, 1); tick(); end
        chk("sat.254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 46; i++) begin drv(4'b0001, nv4(0, 0, 0, i), 0, 1); tick(); end
        chk("sat.255", 32'(drop_cnt), 32'd255);
        drv('0, '0, 0, 0); tick();
        chk("sat.oldest_send", 32'(tx_send), 32'd1);
        chk("sat.oldest_word", tx_word, 32'h21);

        // flush during an in-flight report
        do_reset();
        drv(4'b0100, nv4(0, 32'h77, 0, 0), 0, 0); tick();
        drv('0, '0, 0, 0); tick();
        chk("flf.send", 32'(tx_send), 32'd1);
        drv(4'b0010, nv4(0, 0, 32'h66, 0), 1, 0); tick();
        chk("flf.pend", 32'(pending), 32'd0);
        chk("flf.word", tx_word, 32'h77);
        drv('0, '0, 0, 1); tick();
        drv('0, '0, 0, 0); tick();
        tick();
        chk("flf.nosend", 32'(tx_send), 32'd0);
        drv(4'b1000, nv4(32'h88, 0, 0, 0), 0, 0); tick();
        drv('0, '0, 0, 0); tick();
        chk("flf.next_send", 32'(tx_send), 32'd1);
        chk("flf.next_word", tx_word, 32'h88);

        // busy timeout, then the next pending report still goes out
        do_reset();
        drv(4'b0001, nv4(0, 0, 0, 32'h99), 0, 0); tick();
        drv('0, '0, 0, 0); tick();
        chk("tmo.send", 32'(tx_send), 32'd1);
        drv(4'b0010, nv4(0, 0, 32'hAA, 0), 0, 0); tick();
        drv('0, '0, 0, 0);
        for (int i = 0; i < 14; i++) tick();
        chk("tmo.err_before", 32'(tx_err), 32'd0);
        tick();
        chk("tmo.err_set", 32'(tx_err), 32'd1);
        tick();
        chk("tmo.next_send", 32'(tx_send), 32'd1);
        chk("tmo.next_word", tx_word, 32'hAA);
        chk("tmo.err_sticky", 32'(tx_err), 32'd1);

        // async reset while tx_send is high, and during WAIT_LO
        do_reset();
        drv(4'b0001, nv4(0, 0, 0, 32'h5A), 0, 0); tick();
        drv('0, '0, 0, 0); tick();
        chk("rst.send_hi", 32'(tx_send), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("rst.send_drop", 32'(tx_send), 32'd0);
        chk("rst.word_drop", tx_word, 32'h0);
        tick();
        reset_n = 1'b1;
        drv(4'b0001, nv4(0, 0, 0, 32'h5B), 0, 0); tick();
        drv('0, '0, 0, 0); tick();
        tick();
        drv(4'b0010, nv4(0, 0, 32'h5C, 0), 0, 1); tick();
        chk("rst.wlo_pend", 32'(pending), 32'h2);
        #2 reset_n = 1'b0;
        #1 chk_out("rst.wlo", 0, 32'h0, 4'b0000, 0, 0);
        tick();
        reset_n = 1'b1;
        drv(4'b1000, nv4(32'hCAFE, 0, 0, 0), 0, 0); tick();
        chk("rst.after_pend", 32'(pending), 32'h8);
        drv('0, '0, 0, 0); tick();
        chk("rst.after_send", 32'(tx_send), 32'd1);
        chk("rst.after_word", tx_word, 32'hCAFE);

        // random traffic against the reference model
        do_reset();
        e_wait = 0;
        e_len = 0;
        for (int i = 0; i < 3000; i++) begin
            rb = (e_wait == 0 && e_len > 0);
            for (int c = 0; c < N; c++) begin
                rv[c] = ($urandom_range(0, 5) == 0);
                rn[c*W +: W] = $urandom;
            end
            rf = ($urandom_range(0, 49) == 0);
            drv(rv, rn, rf, rb);
            m_step(rv, rn, rf, rb);
            tick();
            chk_out($sformatf("rand%0d", i), m_send, m_word, m_pvec(), m_drops[7:0], m_err);
            if (rb) e_len--;
            else if (e_len > 0 && e_wait > 0) e_wait--;
            if (e_len == 0) begin
                if (m_send && $urandom_range(0, 9) != 0) begin
                    e_wait = $urandom_range(0, 3);
                    e_len  = $urandom_range(1, 6);
                end else if (!m_active && $urandom_range(0, 39) == 0) begin
                    e_wait = 0;
                    e_len  = $urandom_range(1, 4);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
